receiver_deframer: RTL and testbench



---
 rtl/receiver_deframer_pkg.sv | 11 +
 rtl/receiver_deframer_tag_calc.sv | 12 +
 rtl/receiver_deframer.sv | 78 +++++++
 tb/tb_receiver_deframer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/receiver_deframer_pkg.sv
// receiver_pkg: shared widths, frame field positions and FSM states for the receive deframer
package receiver_pkg;
  localparam int FRAMED_TOTAL_WIDTH = 512;
  localparam int MSG_WIDTH = 488;
  localparam int FRAMER_CNTR_WIDTH = 16;
  localparam int FRAMER_AUTH_WIDTH = 8;
  localparam int MSG_LSB = 24;
  localparam int CNTR_LSB = 8;
  localparam int TAG_LSB = 0;
  typedef enum logic [1:0] {IDLE, CHECK, OUT} state_t;
endpackage

// File: rtl/receiver_deframer_tag_calc.sv
// frame_tag_calc: byte-wise XOR reduction of the tag-covered frame bits
module frame_tag_calc #(
  parameter int W = 504
) (
  input  logic [W-1:0] data,
  output logic [7:0]   tag
);
  always_comb begin
    tag = '0;
    for (int i = 0; i < W / 8; i++) tag ^= data[i*8 +: 8];
  end
endmodule

// File: rtl/receiver_deframer.sv
// receiver_deframer: checks tag and sequence counter of decrypted frames, forwards good messages, drops and counts bad ones
module receiver_deframer
  import receiver_pkg::*;
#(
  parameter int FRAMED_TOTAL_WIDTH = 512,
  parameter int MSG_WIDTH = 488,
  parameter int FRAMER_CNTR_WIDTH = 16,
  parameter int FRAMER_AUTH_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [FRAMED_TOTAL_WIDTH-1:0] in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MSG_WIDTH-1:0]          out_data,
  output logic                          auth_err,
  output logic                          replay_err,
  output logic [FRAMER_CNTR_WIDTH-1:0]  expected_cntr,
  output logic [15:0]                   drop_count
);
  state_t state;
  logic [FRAMED_TOTAL_WIDTH-1:0] frame_reg;
  logic [FRAMER_AUTH_WIDTH-1:0] calc_tag;
  logic tag_ok, cntr_ok;
  logic [15:0] drop_next;
  frame_tag_calc #(.W(FRAMED_TOTAL_WIDTH - CNTR_LSB)) u_tag (
    .data(frame_reg[FRAMED_TOTAL_WIDTH-1:CNTR_LSB]),
    .tag (calc_tag)
  );
  assign tag_ok = calc_tag == frame_reg[TAG_LSB +: FRAMER_AUTH_WIDTH];
  assign cntr_ok = frame_reg[CNTR_LSB +: FRAMER_CNTR_WIDTH] == expected_cntr;
  assign drop_next = drop_count == 16'hFFFF ? drop_count : drop_count + 16'd1;
  assign in_ready = state == IDLE;
  // Tag is judged first; the counter only matters once the tag is trusted
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      frame_reg <= '0;
      expected_cntr <= '0;
      drop_count <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      auth_err <= 1'b0;
      replay_err <= 1'b0;
    end else begin
      auth_err <= 1'b0;
      replay_err <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          frame_reg <= in_data;
          state <= CHECK;
        end
        CHECK: begin
          state <= IDLE;
          if (!tag_ok) begin
            auth_err <= 1'b1;
            drop_count <= drop_next;
          end else if (!cntr_ok) begin
            replay_err <= 1'b1;
            drop_count <= drop_next;
          end else begin
            out_data <= frame_reg[MSG_LSB +: MSG_WIDTH];
            out_valid <= 1'b1;
            expected_cntr <= expected_cntr + FRAMER_CNTR_WIDTH'(1);
            state <= OUT;
          end
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_receiver_deframer.sv
// tb_receiver_deframer: table-driven frame vectors plus wrap, back-pressure, saturation and reset sequences
module tb_receiver_deframer;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [511:0] in_data = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [487:0] out_data;
  logic auth_err, replay_err;
  logic [15:0] expected_cntr, drop_count;
  int total = 0;
  int passed = 0;

  receiver_deframer dut (
    .clk(clk), .resetN(resetN), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .auth_err(auth_err), .replay_err(replay_err), .expected_cntr(expected_cntr), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [487:0] m;
    logic [15:0]  c;
    logic         bad;
    int           kind;
    logic [15:0]  ec;
    logic [15:0]  dc;
  } vec_t;
  vec_t v[8];

  function automatic logic [511:0] mk(input logic [487:0] m, input logic [15:0] c, input logic bad);
    logic [503:0] body;
    logic [7:0] t;
    body = {m, c};
    t = '0;
    for (int i = 0; i < 63; i++) t ^= body[i*8 +: 8];
    return {body, t ^ {7'd0, bad}};
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send(input logic [511:0] f);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", {511'd0, in_ready}, 512'd1);
    in_valid = 1'b1;
    in_data = f;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("in_ready_check", {511'd0, in_ready}, 512'd0);
    chk("out_valid_check", {511'd0, out_valid}, 512'd0);
  endtask

  // kind: 0 accept, 1 auth error, 2 replay error; assumes out_ready high
  task automatic run_vec(input logic [511:0] f, input int kind, input logic [487:0] m,
                         input logic [15:0] ec, input logic [15:0] dc);
    send(f);
    @(posedge clk);
    #1;
    chk("out_valid", {511'd0, out_valid}, {511'd0, kind == 0});
    chk("auth_err", {511'd0, auth_err}, {511'd0, kind == 1});
    chk("replay_err", {511'd0, replay_err}, {511'd0, kind == 2});
    chk("in_ready_after", {511'd0, in_ready}, {511'd0, kind != 0});
    chk("expected_cntr", {496'd0, expected_cntr}, {496'd0, ec});
    chk("drop_count", {496'd0, drop_count}, {496'd0, dc});
    if (kind == 0) chk("out_data", {24'd0, out_data}, {24'd0, m});
    @(posedge clk);
    #1;
    chk("out_valid_end", {511'd0, out_valid}, 512'd0);
    chk("errs_end", {510'd0, auth_err, replay_err}, 512'd0);
    chk("in_ready_end", {511'd0, in_ready}, 512'd1);
  endtask

  initial begin
    logic [487:0] ma, mb, mc;
    ma = {61{8'hA5}} ^ 488'h0123456789ABCDEF;
    mb = {8'h80, 472'd0, 8'h7F};
    mc = 488'hDEADBEEF_CAFEF00D;
    v[0] = '{488'd1, 16'h0000, 1'b0, 0, 16'd1, 16'd0};
    v[1] = '{488'd1, 16'h0000, 1'b1, 1, 16'd1, 16'd1};
    v[2] = '{488'd1, 16'h0000, 1'b0, 2, 16'd1, 16'd2};
    v[3] = '{ma, 16'h0001, 1'b0, 0, 16'd2, 16'd2};
    v[4] = '{ma, 16'h0007, 1'b1, 1, 16'd2, 16'd3};
    v[5] = '{{488{1'b1}}, 16'h0002, 1'b0, 0, 16'd3, 16'd3};
    v[6] = '{mc, 16'h0004, 1'b0, 2, 16'd3, 16'd4};
    v[7] = '{mc, 16'h0003, 1'b0, 0, 16'd4, 16'd4};

    #12;
    chk("rst_in_ready", {511'd0, in_ready}, 512'd1);
    chk("rst_out_valid", {511'd0, out_valid}, 512'd0);
    chk("rst_out_data", {24'd0, out_data}, 512'd0);
    chk("rst_errs", {510'd0, auth_err, replay_err}, 512'd0);
    chk("rst_cntr", {496'd0, expected_cntr}, 512'd0);
    chk("rst_drop", {496'd0, drop_count}, 512'd0);
    @(negedge clk);
    resetN = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(mk(v[i].m, v[i].c, v[i].bad), v[i].kind, v[i].m, v[i].ec, v[i].dc);

    // Counter wrap via backdoor preload
    @(negedge clk);
    force dut.expected_cntr = 16'hFFFF;
    @(posedge clk);
    #1 release dut.expected_cntr;
    run_vec(mk(488'h55, 16'hFFFF, 1'b0), 0, 488'h55, 16'h0000, 16'd4);
    run_vec(mk(488'h66, 16'h0000, 1'b0), 0, 488'h66, 16'h0001, 16'd4);

    // Back-pressure with a second frame waiting
    out_ready = 1'b0;
    send(mk(mb, 16'h0001, 1'b0));
    in_valid = 1'b1;
    in_data = mk(mc, 16'h0002, 1'b0);
    @(posedge clk);
    #1;
    chk("bp_out_valid", {511'd0, out_valid}, 512'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", {511'd0, out_valid}, 512'd1);
      chk("bp_hold_data", {24'd0, out_data}, {24'd0, mb});
      chk("bp_in_ready", {511'd0, in_ready}, 512'd0);
      chk("bp_cntr", {496'd0, expected_cntr}, 512'd2);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", {511'd0, out_valid}, 512'd0);
    chk("bp_release_ready", {511'd0, in_ready}, 512'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("bp_second_taken", {511'd0, in_ready}, 512'd0);
    @(posedge clk);
    #1;
    chk("bp_second_valid", {511'd0, out_valid}, 512'd1);
    chk("bp_second_data", {24'd0, out_data}, {24'd0, mc});
    chk("bp_second_cntr", {496'd0, expected_cntr}, 512'd3);
    @(posedge clk);
    #1;

    // drop_count saturation
    @(negedge clk);
    force dut.drop_count = 16'hFFFE;
    @(posedge clk);
    #1 release dut.drop_count;
    run_vec(mk(488'd9, 16'h0003, 1'b1), 1, 488'd0, 16'd3, 16'hFFFF);
    run_vec(mk(488'd9, 16'h0003, 1'b1), 1, 488'd0, 16'd3, 16'hFFFF);

    // Reset while holding a frame in OUT
    out_ready = 1'b0;
    send(mk(488'h77, 16'h0003, 1'b0));
    @(posedge clk);
    #1 chk("pre_rst_valid", {511'd0, out_valid}, 512'd1);
    @(negedge clk);
    resetN = 1'b0;
    #1;
    chk("mid_rst_valid", {511'd0, out_valid}, 512'd0);
    chk("mid_rst_cntr", {496'd0, expected_cntr}, 512'd0);
    chk("mid_rst_drop", {496'd0, drop_count}, 512'd0);
    chk("mid_rst_ready", {511'd0, in_ready}, 512'd1);
    @(negedge clk);
    resetN = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_errs", {510'd0, auth_err, replay_err}, 512'd0);
      chk("post_rst_valid", {511'd0, out_valid}, 512'd0);
      chk("post_rst_drop", {496'd0, drop_count}, 512'd0);
    end
    run_vec(mk(488'h88, 16'h0000, 1'b0), 0, 488'h88, 16'd1, 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
